alu_result_decoder: RTL

Consumer end of the ALU result interface: accepts an ALU result word with its sign and overflow flags and converts it to sign-magnitude BCD digits for the seven-segment display driver. Conversion is a serial shift-add-3 (double dabble), one bit per clock. Valid/ready handshake on both sides. Sits between the ALU output and the display multiplexer.

---
 rtl/alu_result_decoder_pkg.sv | 29 ++
 rtl/alu_result_decoder_bcd_add3.sv | 25 ++
 rtl/alu_result_decoder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_result_decoder_pkg.sv
// ============================================================================
// | Package     : alu_dec_pkg                                                |
// | Description : Shared types and constants for the ALU result decoder:     |
// |               FSM state encoding, blank digit code and the shift-counter |
// |               width helper.                                              |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
`default_nettype none

package alu_dec_pkg;

  // Decoder control states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } dec_state_e;

  // Digit code the display driver renders as an unlit position.
  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  // Counter must be able to hold the value WIDTH (number of shifts).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : alu_dec_pkg

`default_nettype wire

// File: rtl/alu_result_decoder_bcd_add3.sv
// ============================================================================
// | Module      : bcd_add3                                                   |
// | Description : Combinational double-dabble digit corrector. A digit of 5  |
// |               or more gets +3 so the following left shift carries into   |
// |               the next decade correctly.                                 |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
`default_nettype none

module bcd_add3 (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Per-digit correction; no carry leaves the nibble.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule : bcd_add3

`default_nettype wire

// File: rtl/alu_result_decoder.sv
// ============================================================================
// | Module      : alu_result_decoder                                         |
// | Description : Converts an ALU result word (with sign and overflow flags) |
// |               into sign-magnitude BCD digits using a serial shift-add-3  |
// |               conversion, one bit per clock. Valid/ready on both sides.  |
// | Options     : ALU_DEC_LEADING_ZERO_BLANK_EN - leading zero digits above  |
// |               the least significant digit are replaced by the blank code.|
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
`default_nettype none

module alu_result_decoder
  import alu_dec_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      result,
  input  logic                  sign,
  input  logic                  overflow,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf
);

  localparam int CW = cnt_width(WIDTH);
  localparam int BW = 4 * DIGITS;

  dec_state_e        state_q, state_d;
  logic [WIDTH-1:0]  mag_q,   mag_d;
  logic [BW-1:0]     acc_q,   acc_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic [BW-1:0]     bcd_q,   bcd_d;
  logic              neg_q,   neg_d;
  logic              ovf_q,   ovf_d;

  logic [BW-1:0]     acc_adj;    // accumulator after per-digit correction
  logic [BW-1:0]     acc_shift;  // corrected accumulator shifted, magnitude MSB in
  logic [BW-1:0]     load_raw;   // digits about to be presented (plain BCD)
  logic [BW-1:0]     load_fmt;   // same digits after optional blanking

  // One corrector per BCD digit of the accumulator.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_in  (acc_q[4*g +: 4]),
      .digit_out (acc_adj[4*g +: 4])
    );
  end

  // Shift the {accumulator, magnitude} pair left by one bit.
  always_comb begin
    acc_shift = (acc_adj << 1) | {{(BW-1){1'b0}}, mag_q[WIDTH-1]};
  end

  // Digits loaded on entry to DONE: final shift result, or zero for overflow.
  always_comb begin
    load_raw = '0;
    if (state_q == S_SHIFT) begin
      load_raw = acc_shift;
    end
  end

  // Optional leading-zero blanking; the least significant digit always shows.
  always_comb begin
    load_fmt = load_raw;
`ifdef ALU_DEC_LEADING_ZERO_BLANK_EN
    begin : blk_blank
      logic leading;
      leading = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
        if (leading && (load_raw[4*i +: 4] == 4'd0)) begin
          load_fmt[4*i +: 4] = BLANK_DIGIT;
        end else begin
          leading = 1'b0;
        end
      end
    end
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (overflow) begin
            // Overflow skips conversion and shows a zero value with the flag.
            bcd_d   = load_fmt;
            neg_d   = 1'b0;
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            // Two's complement negate; 8'h80 negates to 128 unsigned.
            mag_d   = sign ? (~result + WIDTH'(1)) : result;
            neg_d   = sign;
            ovf_d   = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        acc_d = acc_shift;
        mag_d = mag_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          bcd_d   = load_fmt;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign bcd       = bcd_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

endmodule : alu_result_decoder

`default_nettype wire
